// File: rtl/axa_pkg.sv
`default_nettype none
// =============================================================================
// Module   : axa_pkg
// Purpose  : Bit-cell mode enum and default parameters for approx_adder_pipe.
// Revision : 1.0
// =============================================================================
package axa_pkg;

   typedef enum logic {
      CELL_EXACT = 1'b0,
      CELL_AXA3  = 1'b1
   } cell_mode_e;

   localparam int AXA_WIDTH_DEF  = 16;
   localparam int AXA_STAGES_DEF = 4;
   localparam int AXA_ERR_W_DEF  = 16;

endpackage
`default_nettype wire

// File: rtl/axa_cell.sv
`default_nettype none
// =============================================================================
// Module   : axa_cell
// Purpose  : One-bit adder cell, exact or approximate sum with an exact carry.
// Revision : 1.0
// =============================================================================
module axa_cell
   import axa_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic mode,
   output logic s,
   output logic cout
);

   assign cout = (a & b) | (a & cin) | (b & cin);
   assign s    = (mode == CELL_AXA3) ? (cin & ~(a ^ b)) : (a ^ b ^ cin);

endmodule
`default_nettype wire

// File: rtl/approx_adder_pipe.sv
`default_nettype none
// =============================================================================
// Module   : approx_adder_pipe
// Purpose  : Elastic pipelined adder with per-transaction approximate LSBs.
//            AXA_ERRSTAT_EN builds the exact shadow sum and mismatch counter.
// Revision : 1.0
// =============================================================================
module approx_adder_pipe
   import axa_pkg::*;
#(
   parameter int WIDTH  = AXA_WIDTH_DEF,
   parameter int STAGES = AXA_STAGES_DEF,
   parameter int ERR_W  = AXA_ERR_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic                       cin,
   input  logic [$clog2(WIDTH+1)-1:0] approx_k,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH:0]             r,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       err_clr,
   output logic [ERR_W-1:0]           err_cnt
);

   localparam int SEG = WIDTH / STAGES;
   localparam int KW  = $clog2(WIDTH + 1);
   localparam int RW  = WIDTH + 1;

   if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("approx_adder_pipe: WIDTH must be a multiple of STAGES");
   end

   logic             vld     [STAGES];
   logic             cy      [STAGES];
   logic [WIDTH-1:0] op_a    [STAGES];
   logic [WIDTH-1:0] op_b    [STAGES];
   logic [WIDTH-1:0] sum     [STAGES];
   logic [KW-1:0]    kk      [STAGES];
   logic [STAGES-1:0] rdy;

   logic             src_v   [STAGES];
   logic             src_c   [STAGES];
   logic [WIDTH-1:0] src_a   [STAGES];
   logic [WIDTH-1:0] src_b   [STAGES];
   logic [WIDTH-1:0] src_sum [STAGES];
   logic [KW-1:0]    src_k   [STAGES];
   logic             nxt_c   [STAGES];
   logic [WIDTH-1:0] nxt_sum [STAGES];

   // A stage may load when it is empty or its content leaves this cycle.
   always_comb begin
      rdy = '0;
      rdy[STAGES-1] = !vld[STAGES-1] || out_ready;
      for (int s = STAGES - 2; s >= 0; s--) begin
         rdy[s] = !vld[s] || rdy[s+1];
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [SEG-1:0]   seg_s;
      logic [WIDTH-1:0] merged;

      if (s == 0) begin : g_head
         assign src_v[s]   = in_valid;
         assign src_c[s]   = cin;
         assign src_a[s]   = a;
         assign src_b[s]   = b;
         assign src_k[s]   = approx_k;
         assign src_sum[s] = '0;
      end else begin : g_body
         assign src_v[s]   = vld[s-1];
         assign src_c[s]   = cy[s-1];
         assign src_a[s]   = op_a[s-1];
         assign src_b[s]   = op_b[s-1];
         assign src_k[s]   = kk[s-1];
         assign src_sum[s] = sum[s-1];
      end

      // Each bit owns its carry net so the ripple chain is not one shared vector.
      for (genvar j = 0; j < SEG; j++) begin : g_bit
         localparam int            BIT     = s * SEG + j;
         localparam logic [KW-1:0] BIT_IDX = KW'(BIT);
         cell_mode_e mode;
         logic       c_in;
         logic       c_out;

         if (j == 0) begin : g_c0
            assign c_in = src_c[s];
         end else begin : g_cn
            assign c_in = g_bit[j-1].c_out;
         end

         assign mode = (src_k[s] > BIT_IDX) ? CELL_AXA3 : CELL_EXACT;

         axa_cell u_cell (
            .a    (src_a[s][BIT]),
            .b    (src_b[s][BIT]),
            .cin  (c_in),
            .mode (mode),
            .s    (seg_s[j]),
            .cout (c_out)
         );
      end

      always_comb begin
         merged = src_sum[s];
         merged[s*SEG +: SEG] = seg_s;
      end

      assign nxt_sum[s] = merged;
      assign nxt_c[s]   = g_bit[SEG-1].c_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            vld[s]  <= 1'b0;
            cy[s]   <= 1'b0;
            op_a[s] <= '0;
            op_b[s] <= '0;
            sum[s]  <= '0;
            kk[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (rdy[s]) begin
               vld[s] <= src_v[s];
               if (src_v[s]) begin
                  cy[s]   <= nxt_c[s];
                  op_a[s] <= src_a[s];
                  op_b[s] <= src_b[s];
                  sum[s]  <= nxt_sum[s];
                  kk[s]   <= src_k[s];
               end
            end
         end
      end
   end

   assign r         = {cy[STAGES-1], sum[STAGES-1]};
   assign out_valid = vld[STAGES-1];
   assign in_ready  = rdy[0];

`ifdef AXA_ERRSTAT_EN
   logic [WIDTH:0]   ex     [STAGES];
   logic [WIDTH:0]   src_ex [STAGES];
   logic [ERR_W-1:0] err_q;
   logic             mismatch;

   for (genvar s = 0; s < STAGES; s++) begin : g_exact
      if (s == 0) begin : g_ex_head
         assign src_ex[s] = {1'b0, a} + {1'b0, b} + RW'(cin);
      end else begin : g_ex_body
         assign src_ex[s] = ex[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            ex[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (rdy[s] && src_v[s]) begin
               ex[s] <= src_ex[s];
            end
         end
      end
   end

   assign mismatch = (r != ex[STAGES-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else if (err_clr) begin
         err_q <= '0;
      end else if (out_valid && out_ready && mismatch && (err_q != {ERR_W{1'b1}})) begin
         err_q <= err_q + 1'b1;
      end
   end

   assign err_cnt = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_approx_adder_pipe
// Purpose  : Self-checking bench for approx_adder_pipe (AXA_ERRSTAT_EN aware).
// Revision : 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_approx_adder_pipe;

   localparam int W  = 16;
   localparam int S  = 4;
   localparam int EW = 16;
   localparam int KW = $clog2(W + 1);
`ifdef AXA_ERRSTAT_EN
   localparam bit ERRSTAT = 1'b1;
`else
   localparam bit ERRSTAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic          cin = 1'b0;
   logic [KW-1:0] approx_k = '0;
   logic          in_valid = 1'b0, in_ready;
   logic [W:0]    r;
   logic          out_valid, out_ready = 1'b1, err_clr = 1'b0;
   logic [EW-1:0] err_cnt;

   logic [W-1:0]  s_a = '0, s_b = '0;
   logic          s_cin = 1'b0;
   logic [KW-1:0] s_k = '0;
   logic          s_valid = 1'b0, s_ready, s_ov, s_clr = 1'b0;
   logic          s_out_ready = 1'b1;
   logic [W:0]    s_r;
   logic [2:0]    s_err;

   approx_adder_pipe #(.WIDTH(W), .STAGES(S), .ERR_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .approx_k(approx_k),
      .in_valid(in_valid), .in_ready(in_ready), .r(r), .out_valid(out_valid),
      .out_ready(out_ready), .err_clr(err_clr), .err_cnt(err_cnt));

   approx_adder_pipe #(.WIDTH(W), .STAGES(S), .ERR_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .a(s_a), .b(s_b), .cin(s_cin), .approx_k(s_k),
      .in_valid(s_valid), .in_ready(s_ready), .r(s_r), .out_valid(s_ov),
      .out_ready(s_out_ready), .err_clr(s_clr), .err_cnt(s_err));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   int n_acc = 0, n_out = 0, t_last = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact carries drive every bit; approximate bits keep only cin & ~(a^b).
   function automatic logic [W:0] exact_r(logic [W-1:0] x, logic [W-1:0] y, logic c);
      longint unsigned xs = x, ys = y, cs = c;
      return (W+1)'(xs + ys + cs);
   endfunction

   function automatic logic [W:0] model_r(logic [W-1:0] x, logic [W-1:0] y, logic c, int k);
      logic [W:0] res;
      longint unsigned xs = x, ys = y, cs = c, m, ci;
      res = '0;
      for (int i = 0; i < W; i++) begin
         m  = 64'd1 << i;
         ci = ((xs % m) + (ys % m) + cs) >> i;
         res[i] = (i < k) ? (ci[0] & ~(x[i] ^ y[i])) : (x[i] ^ y[i] ^ ci[0]);
      end
      res[W] = exact_r(x, y, c)[W];
      return res;
   endfunction

   typedef struct {
      logic [W:0] rr;
      logic       mis;
      int         t;
   } item_t;

   item_t         q[$];
   logic [EW-1:0] exp_err = '0;
   logic          hold_v = 1'b0;
   logic [W:0]    held_r = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         exp_err = '0;
         hold_v  = 1'b0;
         chk("reset_out_valid", 64'(out_valid), 64'd0);
         chk("reset_r", 64'(r), 64'd0);
         chk("reset_err_cnt", 64'(err_cnt), 64'd0);
      end else begin
         chk("out_valid", 64'(out_valid), 64'((q.size() > 0) && (cyc - q[0].t >= S)));
         chk("in_ready", 64'(in_ready), 64'((q.size() < S) || out_ready));
         if (hold_v) chk("r_hold", 64'(r), 64'(held_r));
         if (out_valid && q.size() > 0) chk("r_value", 64'(r), 64'(q[0].rr));
         chk("err_cnt", 64'(err_cnt), 64'(exp_err));
         if (err_clr) exp_err = '0;
         else if (ERRSTAT && out_valid && out_ready && q.size() > 0 && q[0].mis && exp_err != '1)
            exp_err = exp_err + 1'b1;
         if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
         end
         hold_v = out_valid && !out_ready;
         held_r = r;
         if (in_valid && in_ready) begin
            q.push_back('{model_r(a, b, cin, int'(approx_k)),
                          model_r(a, b, cin, int'(approx_k)) != exact_r(a, b, cin), cyc});
            n_acc++;
         end
      end
   end

   task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic c, logic [KW-1:0] k);
      logic acc;
      a = x; b = y; cin = c; approx_k = k; in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) t_last = cyc;
         @(posedge clk);
         #1;
         if (acc) return;
      end
      n_chk++; n_fail++;
      $display("FAIL send_timeout: actual no transfer required transfer within 200 cycles");
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = cyc - t_last;
            return;
         end
      end
      n_chk++; n_fail++;
      $display("FAIL wait_out_timeout: actual no out_valid required out_valid within 30 cycles");
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && q.size() > 0; n++) @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   int  lat, base_acc, base_out;
   bit  done;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hold_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", 64'(in_ready), 64'd1);

      chk("model_pin_ffff_1", 64'(model_r(16'hFFFF, 16'h0001, 1'b0, 0)), 64'h10000);
      chk("model_pin_k4", 64'(model_r(16'h0001, 16'h0000, 1'b0, 4)), 64'h0);
      chk("model_pin_k16_cin", 64'(model_r(16'h0000, 16'h0000, 1'b1, 16)), 64'h1);
      chk("model_pin_k16_5", 64'(model_r(16'h0005, 16'h0000, 1'b0, 16)), 64'h0);
      chk("model_pin_allax_carry", 64'(model_r(16'hFFFF, 16'h0000, 1'b1, 16)), 64'h10000);

      // Exact add with a full carry ripple
      @(posedge clk); #1;
      send(16'hFFFF, 16'h0001, 1'b0, 5'd0);
      in_valid = 1'b0;
      wait_out(lat);
      chk("latency", 64'(lat), 64'(S));
      chk("r_ffff_plus_1", 64'(r), 64'h10000);
      @(negedge clk);
      chk("err_after_exact", 64'(err_cnt), 64'd0);

      send(16'h0001, 16'h0000, 1'b0, 5'd4);
      in_valid = 1'b0;
      wait_out(lat);
      chk("r_k4", 64'(r), 64'h0);
      @(negedge clk);
      chk("err_after_k4", 64'(err_cnt), ERRSTAT ? 64'd1 : 64'd0);
      send(16'h0000, 16'h0000, 1'b1, 5'd16);
      in_valid = 1'b0;
      wait_out(lat);
      chk("r_k16_cin", 64'(r), 64'h1);
      @(negedge clk);
      chk("err_after_k16", 64'(err_cnt), ERRSTAT ? 64'd1 : 64'd0);

      // Backpressure: six back-to-back inputs against a stalled output
      @(posedge clk); #1 out_ready = 1'b0;
      base_acc = n_acc; base_out = n_out;
      fork
         begin
            for (int i = 1; i <= 6; i++)
               send(W'(i * 16'h1111), W'(i), 1'(i), KW'(i));
            in_valid = 1'b0;
         end
         begin
            repeat (12) @(negedge clk);
            chk("bp_accepted", 64'(n_acc - base_acc), 64'd4);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_outputs", 64'(n_out - base_out), 64'd6);

      // Randomized traffic with random backpressure and occasional clears
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [W-1:0] x, y;
               x = W'($urandom);
               y = ($urandom_range(0, 3) == 0) ? ~x : W'($urandom);
               send(x, y, 1'($urandom), KW'($urandom_range(0, 31)));
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  repeat ($urandom_range(1, 2)) @(posedge clk);
                  #1;
               end
            end
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 9) < 7);
               err_clr   = ($urandom_range(0, 19) == 0);
            end
         end
      join
      out_ready = 1'b1;
      err_clr   = 1'b0;
      drain();

      // Saturation and clear priority on a 3-bit counter instance
      @(posedge clk); #1;
      s_valid = 1'b1; s_a = 16'h0001; s_b = 16'h0000; s_cin = 1'b0; s_k = 5'd16;
      repeat (9) begin
         @(negedge clk);
         chk("sat_in_ready", 64'(s_ready), 64'd1);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("sat_saturated", 64'(s_err), ERRSTAT ? 64'd7 : 64'd0);
      chk("sat_r", 64'(s_r), 64'd0);
      @(posedge clk); #1 s_clr = 1'b1;
      @(posedge clk); #1 s_clr = 1'b0;
      @(negedge clk);
      chk("sat_cleared", 64'(s_err), 64'd0);
      @(posedge clk); #1 s_valid = 1'b1;
      @(posedge clk); #1 s_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("sat_one", 64'(s_err), ERRSTAT ? 64'd1 : 64'd0);
      @(posedge clk); #1 s_valid = 1'b1;
      @(posedge clk); #1 s_valid = 1'b0;
      for (int n = 0; n < 20 && !s_ov; n++) @(negedge clk);
      chk("sat_out_seen", 64'(s_ov), 64'd1);
      s_clr = 1'b1;
      @(posedge clk); #1 s_clr = 1'b0;
      @(negedge clk);
      chk("clr_priority", 64'(s_err), 64'd0);

      // Reset with transactions in flight
      @(posedge clk); #1 out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(16'h00F0, W'(i), 1'b0, 5'd8);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_async_out_valid", 64'(out_valid), 64'd0);
      chk("rst_async_r", 64'(r), 64'd0);
      chk("rst_async_err", 64'(err_cnt), 64'd0);
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("no_stale_output", 64'(out_valid), 64'd0);
      end
      chk("in_ready_post_reset", 64'(in_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual still running required finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
